irq_pending_latch: RTL and testbench
====================================

Name: irq_pending_latch

Overview:
- Upstream stage of the 4-to-2 priority encoder. It takes four asynchronous request lines, synchronises them and detects rising edges.
- Each detected edge is held as a pending bit until it is acknowledged.
- Masked pending bits go out as D_OUT[3:0], with D_OUT[3] driving D3 (highest priority) through D_OUT[0] driving D0.
- The encoder's A1/A0 result comes back as ACK_IDX to retire the serviced request.

Parameters:
- NUM_CH, 4, number of request channels; fixed at 4 to match the encoder width.
- SYNC_STAGES, 2, synchroniser depth per channel; legal values are 2 or 3.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- REQ  in  4  asynchronous request levels; each rising edge is one event.
- MASK  in  4  1 = channel hidden from D_OUT; the channel still latches.
- ACK  in  1  one-cycle pulse; retires the pending bit selected by ACK_IDX.
- ACK_IDX  in  2  channel index to clear; driven by the encoder {A1,A0}.
- CLR_OVR  in  1  one-cycle pulse; clears all OVERRUN bits.
- D_OUT  out  4  pending & ~MASK; feeds encoder D3..D0.
- IRQ  out  1  OR of D_OUT.
- OVERRUN  out  4  sticky; set when a channel sees an edge while already pending.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - Reset is asynchronous and active-low on rst_n; the polarity and synchronicity are fixed.
  - While rst_n = 0, every flop is 0: synchroniser stages, previous-value flop, pending[3:0] and OVERRUN[3:0]. D_OUT = 0 and IRQ = 0.
- Synchroniser:
  - Per channel, a chain of SYNC_STAGES flops gives s[i].
  - A prev[i] flop holds the previous value of s[i].
  - edge[i] = s[i] & ~prev[i].
- Latency:
  - REQ[i] stable high before clk edge 1 gives s[i] = 1 after edge SYNC_STAGES.
  - pending[i] = 1 after edge SYNC_STAGES+1, so 3 edges at the default.
  - D_OUT and IRQ are combinational from the registers, so they are valid in that same cycle.
- Level held from reset: prev resets to 0, so a REQ line already high at reset release counts as one edge.
- Level held after latching: a REQ line held high produces no further events; a new event needs a low-then-high transition.
- Pending update, per channel i at each clk edge:
  - set = edge[i]; clr = ACK & (ACK_IDX == i).
  - If set, pending[i] becomes 1. Set wins over a simultaneous clear, so the new event is retained.
  - Else if clr, pending[i] becomes 0.
  - Otherwise pending[i] holds.
- ACK on a channel that is not pending has no effect and raises no error.
- ACK on a masked channel still clears that channel.
- MASK:
  - Affects only D_OUT and IRQ; it never blocks latching.
  - Unmasking a pending channel makes it visible combinationally in the same cycle.
- OVERRUN:
  - OVERRUN[i] is set when edge[i] & pending[i] & ~clr, i.e. an event arrives on a pending channel that is not being retired.
  - An edge coinciding with its own ACK is not an overrun.
  - CLR_OVR clears all OVERRUN bits. If a set condition occurs in the same cycle as CLR_OVR, set wins.
- Multiple simultaneous edges latch independently, all in the same cycle.
- Reset mid-operation: all pending and OVERRUN state is lost immediately (asynchronous). Events in flight in the synchroniser are discarded.

Decomposition:
- Shared package: NUM_CH_C = 4, IDX_W = 2, and a channel-index type (2-bit).
- One natural sub-module, irq_edge_sync: one channel's synchroniser chain, prev flop and edge output, with parameter SYNC_STAGES.
  - Instantiated NUM_CH times via generate.
- The pending/overrun logic stays in the top level.

Test Plan:
- Reset, then REQ = 4'b0000 for 10 cycles -> D_OUT = 0, IRQ = 0, OVERRUN = 0 throughout.
- REQ[2] rises before edge 1 -> D_OUT = 4'b0100 and IRQ = 1 after edge 3, not before; ACK = 1 with ACK_IDX = 2 -> D_OUT = 0 on the next edge.
- REQ = 4'b1010 together -> D_OUT = 4'b1010 after edge 3; ACK with ACK_IDX = 3 -> D_OUT = 4'b0010; ACK with ACK_IDX = 0 -> no change; ACK with ACK_IDX = 1 -> 0.
- MASK = 4'b0001 and REQ[0] pulsed -> D_OUT = 0 and IRQ = 0 while masked; MASK = 0 -> D_OUT = 4'b0001 in the same cycle.
- With pending[1] = 1, pulse REQ[1] low then high -> OVERRUN = 4'b0010 and pending[1] still 1; CLR_OVR -> OVERRUN = 0.
- The second REQ[1] edge coincides with ACK, ACK_IDX = 1 -> pending[1] stays 1 and OVERRUN[1] stays 0.
- REQ = 4'b1111 latched, then rst_n pulsed low for 3 ns between clock edges -> all outputs are 0 immediately. With REQ still high after release, D_OUT = 4'b1111 again after 3 edges.

Source files
------------

// File: rtl/irq_pending_latch_pkg.sv
// Shared definitions for the interrupt pending-latch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   NUM_CH_C  - channel count, tied to the 4-to-2 encoder width
//   IDX_W     - width of a channel index
//   ch_idx_t  - channel index type, matches the encoder {A1,A0} result
//   ch_onehot - decodes a channel index to a one-hot channel vector
package irq_pending_latch_pkg;

   localparam int NUM_CH_C = 4;
   localparam int IDX_W    = 2;

   typedef logic [IDX_W-1:0] ch_idx_t;

   // One-hot decode of a channel index. Used to steer the acknowledge
   // pulse onto exactly one pending bit.
   function automatic logic [NUM_CH_C-1:0] ch_onehot(input ch_idx_t idx);
      logic [NUM_CH_C-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One request channel: metastability synchroniser plus rising-edge detector.
// Latency: req high before clock edge 1 -> rise high after edge SYNC_STAGES.
// Backpressure: none; every rising edge is reported for exactly one cycle.
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset, clears the chain and prev flop
//   req   - asynchronous request level
//   sync  - synchronised request level (last chain stage)
//   rise  - one-cycle pulse on a 0->1 transition of sync
module irq_edge_sync #(
   parameter int SYNC_STAGES = 2   // 2 or 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   output logic sync,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Bit 0 is the flop that may go metastable; only the last stage is used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], req};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign sync = chain[SYNC_STAGES-1];

   // prev resets to 0, so a line already high at reset release yields
   // exactly one event.
   assign rise = sync & ~prev;

endmodule

// File: rtl/irq_pending_latch.sv
// Latches rising edges of four async request lines until acknowledged.
// Latency: REQ edge -> D_OUT/IRQ after SYNC_STAGES+1 clock edges.
// Backpressure: none; an edge on an already-pending channel sets OVERRUN.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   REQ[3:0]   - asynchronous request levels, one event per rising edge
//   MASK[3:0]  - hides a channel from D_OUT/IRQ without blocking latching
//   ACK        - one-cycle pulse retiring the channel named by ACK_IDX
//   ACK_IDX    - channel to retire, driven by the encoder {A1,A0}
//   CLR_OVR    - one-cycle pulse clearing all OVERRUN bits
//   D_OUT[3:0] - pending & ~MASK, D_OUT[3] feeds encoder D3 (highest)
//   IRQ        - OR of D_OUT
//   OVERRUN    - sticky per-channel flag: event arrived while pending
module irq_pending_latch
   import irq_pending_latch_pkg::*;
#(
   parameter int NUM_CH      = NUM_CH_C,  // fixed to the encoder width
   parameter int SYNC_STAGES = 2          // 2 or 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] REQ,
   input  logic [NUM_CH-1:0] MASK,
   input  logic              ACK,
   input  ch_idx_t           ACK_IDX,
   input  logic              CLR_OVR,
   output logic [NUM_CH-1:0] D_OUT,
   output logic              IRQ,
   output logic [NUM_CH-1:0] OVERRUN
);

   logic [NUM_CH-1:0] sync_lvl;   // synchronised levels, kept for visibility
   logic [NUM_CH-1:0] rise;       // per-channel edge pulses
   logic [NUM_CH-1:0] clr;        // per-channel acknowledge
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] pending_nxt;
   logic [NUM_CH-1:0] ovr_set;
   logic [NUM_CH-1:0] overrun_q;
   logic [NUM_CH-1:0] overrun_nxt;

   // ------------------------------------------------------------------
   // Per-channel synchroniser and edge detector
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      irq_edge_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .req   (REQ[i]),
         .sync  (sync_lvl[i]),
         .rise  (rise[i])
      );
   end

   // ------------------------------------------------------------------
   // Pending / overrun next-state
   // ------------------------------------------------------------------
   // An ACK to a channel that is not pending simply clears an already
   // clear bit; nothing else reacts to it.
   assign clr = ACK ? ch_onehot(ACK_IDX) : '0;

   always_comb begin
      pending_nxt = pending;
      ovr_set     = '0;
      overrun_nxt = overrun_q;
      // A new edge beats a simultaneous acknowledge so the event is not
      // lost; the acknowledge only retires the older one.
      pending_nxt = rise | (pending & ~clr);
      // An edge landing on a channel being retired this cycle replaces
      // the retired event, so it is not counted as an overrun.
      ovr_set     = rise & pending & ~clr;
      // A fresh overrun survives a same-cycle CLR_OVR.
      overrun_nxt = ovr_set | (CLR_OVR ? '0 : overrun_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         overrun_q <= '0;
      end else begin
         pending   <= pending_nxt;
         overrun_q <= overrun_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: combinational from the registers so an unmask is visible
   // in the same cycle.
   // ------------------------------------------------------------------
   assign D_OUT   = pending & ~MASK;
   assign IRQ     = |D_OUT;
   assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;
   import irq_pending_latch_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [3:0] REQ;
   logic [3:0] MASK;
   logic       ACK;
   ch_idx_t    ACK_IDX;
   logic       CLR_OVR;
   logic [3:0] D_OUT;
   logic       IRQ;
   logic [3:0] OVERRUN;

   int checks;
   int errors;

   irq_pending_latch #(
      .NUM_CH      (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .REQ     (REQ),
      .MASK    (MASK),
      .ACK     (ACK),
      .ACK_IDX (ACK_IDX),
      .CLR_OVR (CLR_OVR),
      .D_OUT   (D_OUT),
      .IRQ     (IRQ),
      .OVERRUN (OVERRUN)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and settle 1 ns past it.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; REQ = '0; MASK = '0; ACK = 1'b0; ACK_IDX = '0; CLR_OVR = 1'b0;
      tick(2);
      checks++;
      if (D_OUT !== 4'b0000 || IRQ !== 1'b0 || OVERRUN !== 4'b0000) begin
         errors++;
         $display("FAIL reset_hold: D_OUT=%b IRQ=%b OVERRUN=%b want 0000/0/0000", D_OUT, IRQ, OVERRUN);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         checks++;
         if (D_OUT !== 4'b0000 || IRQ !== 1'b0 || OVERRUN !== 4'b0000) begin
            errors++;
            $display("FAIL idle_cycle%0d: D_OUT=%b IRQ=%b OVERRUN=%b want 0000/0/0000", c, D_OUT, IRQ, OVERRUN);
         end
      end
   endtask

   task automatic test_single();
      REQ = 4'b0100;
      for (int e = 1; e <= 2; e++) begin
         tick(1);
         checks++;
         if (D_OUT !== 4'b0000 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL single_early_e%0d: D_OUT=%b IRQ=%b want 0000/0", e, D_OUT, IRQ);
         end
      end
      tick(1);
      checks++;
      if (D_OUT !== 4'b0100 || IRQ !== 1'b1) begin
         errors++;
         $display("FAIL single_latch: D_OUT=%b IRQ=%b want 0100/1", D_OUT, IRQ);
      end
      ACK = 1'b1; ACK_IDX = 2'd2;
      tick(1);
      ACK = 1'b0;
      checks++;
      if (D_OUT !== 4'b0000 || IRQ !== 1'b0) begin
         errors++;
         $display("FAIL single_ack: D_OUT=%b IRQ=%b want 0000/0", D_OUT, IRQ);
      end
      // Level still high: no new event.
      tick(3);
      checks++;
      if (D_OUT !== 4'b0000) begin
         errors++;
         $display("FAIL single_held_level: D_OUT=%b want 0000", D_OUT);
      end
      REQ = '0;
      tick(3);
   endtask

   task automatic test_pair();
      REQ = 4'b1010;
      tick(3);
      checks++;
      if (D_OUT !== 4'b1010) begin
         errors++;
         $display("FAIL pair_latch: D_OUT=%b want 1010", D_OUT);
      end
      ACK = 1'b1; ACK_IDX = 2'd3;
      tick(1);
      checks++;
      if (D_OUT !== 4'b0010) begin
         errors++;
         $display("FAIL pair_ack3: D_OUT=%b want 0010", D_OUT);
      end
      ACK_IDX = 2'd0;
      tick(1);
      checks++;
      if (D_OUT !== 4'b0010 || OVERRUN !== 4'b0000) begin
         errors++;
         $display("FAIL pair_ack0_nop: D_OUT=%b OVERRUN=%b want 0010/0000", D_OUT, OVERRUN);
      end
      ACK_IDX = 2'd1;
      tick(1);
      ACK = 1'b0;
      checks++;
      if (D_OUT !== 4'b0000 || IRQ !== 1'b0) begin
         errors++;
         $display("FAIL pair_ack1: D_OUT=%b IRQ=%b want 0000/0", D_OUT, IRQ);
      end
      REQ = '0;
      tick(3);
   endtask

   task automatic test_mask();
      MASK = 4'b0001;
      REQ  = 4'b0001;
      tick(1);
      REQ  = 4'b0000;
      tick(3);
      checks++;
      if (D_OUT !== 4'b0000 || IRQ !== 1'b0) begin
         errors++;
         $display("FAIL mask_hidden: D_OUT=%b IRQ=%b want 0000/0", D_OUT, IRQ);
      end
      MASK = 4'b0000;
      #1;
      checks++;
      if (D_OUT !== 4'b0001 || IRQ !== 1'b1) begin
         errors++;
         $display("FAIL mask_unmask_comb: D_OUT=%b IRQ=%b want 0001/1", D_OUT, IRQ);
      end
      // ACK on a masked channel still clears it.
      MASK = 4'b0001;
      ACK = 1'b1; ACK_IDX = 2'd0;
      tick(1);
      ACK = 1'b0;
      MASK = 4'b0000;
      #1;
      checks++;
      if (D_OUT !== 4'b0000) begin
         errors++;
         $display("FAIL mask_ack_masked: D_OUT=%b want 0000", D_OUT);
      end
   endtask

   task automatic test_overrun();
      REQ = 4'b0010;
      tick(3);
      REQ = 4'b0000;
      tick(3);
      REQ = 4'b0010;
      tick(3);
      checks++;
      if (OVERRUN !== 4'b0010 || D_OUT !== 4'b0010) begin
         errors++;
         $display("FAIL ovr_set: OVERRUN=%b D_OUT=%b want 0010/0010", OVERRUN, D_OUT);
      end
      CLR_OVR = 1'b1;
      tick(1);
      CLR_OVR = 1'b0;
      checks++;
      if (OVERRUN !== 4'b0000 || D_OUT !== 4'b0010) begin
         errors++;
         $display("FAIL ovr_clear: OVERRUN=%b D_OUT=%b want 0000/0010", OVERRUN, D_OUT);
      end
      // Overrun set coinciding with CLR_OVR: set wins.
      REQ = 4'b0000;
      tick(3);
      REQ = 4'b0010;
      tick(2);
      CLR_OVR = 1'b1;
      tick(1);
      CLR_OVR = 1'b0;
      checks++;
      if (OVERRUN !== 4'b0010) begin
         errors++;
         $display("FAIL ovr_set_beats_clr: OVERRUN=%b want 0010", OVERRUN);
      end
      CLR_OVR = 1'b1;
      tick(1);
      CLR_OVR = 1'b0;
   endtask

   task automatic test_ack_collide();
      // pending[1] is still 1 from the overrun test.
      REQ = 4'b0000;
      tick(3);
      REQ = 4'b0010;
      tick(2);
      ACK = 1'b1; ACK_IDX = 2'd1;
      tick(1);
      ACK = 1'b0;
      checks++;
      if (D_OUT !== 4'b0010 || OVERRUN !== 4'b0000) begin
         errors++;
         $display("FAIL collide: D_OUT=%b OVERRUN=%b want 0010/0000", D_OUT, OVERRUN);
      end
      ACK = 1'b1; ACK_IDX = 2'd1;
      tick(1);
      ACK = 1'b0;
      checks++;
      if (D_OUT !== 4'b0000) begin
         errors++;
         $display("FAIL collide_retire: D_OUT=%b want 0000", D_OUT);
      end
      REQ = 4'b0000;
      tick(3);
   endtask

   task automatic test_reset_mid();
      REQ = 4'b1111;
      tick(3);
      checks++;
      if (D_OUT !== 4'b1111 || IRQ !== 1'b1) begin
         errors++;
         $display("FAIL mid_latch_all: D_OUT=%b IRQ=%b want 1111/1", D_OUT, IRQ);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (D_OUT !== 4'b0000 || IRQ !== 1'b0 || OVERRUN !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_async: D_OUT=%b IRQ=%b OVERRUN=%b want 0000/0/0000", D_OUT, IRQ, OVERRUN);
      end
      #2 rst_n = 1'b1;
      for (int e = 1; e <= 2; e++) begin
         tick(1);
         checks++;
         if (D_OUT !== 4'b0000) begin
            errors++;
            $display("FAIL mid_relatch_early_e%0d: D_OUT=%b want 0000", e, D_OUT);
         end
      end
      tick(1);
      checks++;
      if (D_OUT !== 4'b1111 || OVERRUN !== 4'b0000) begin
         errors++;
         $display("FAIL mid_relatch: D_OUT=%b OVERRUN=%b want 1111/0000", D_OUT, OVERRUN);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_pair();
      test_mask();
      test_overrun();
      test_ack_collide();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
